// File: rtl/id_ex_skid_stage.sv
// ID/EX boundary: two-entry skid buffer with WB write-through,
// load-use interlock, flush and a saturating bubble counter.
module id_ex_skid_stage #(
  parameter int XLEN     = 32,
  parameter int REG_ADDR = 5,
  parameter int CTRL_W   = 16,
  parameter int STAT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [XLEN-1:0]     i_pc,
  input  logic [CTRL_W-1:0]   i_ctrl,
  input  logic                i_mem_rd,
  input  logic [REG_ADDR-1:0] i_rd,
  input  logic [REG_ADDR-1:0] i_rs1_addr,
  input  logic [REG_ADDR-1:0] i_rs2_addr,
  input  logic                i_rs1_used,
  input  logic                i_rs2_used,
  input  logic [XLEN-1:0]     i_rs1_data,
  input  logic [XLEN-1:0]     i_rs2_data,
  input  logic [XLEN-1:0]     i_imm,
  input  logic                i_wb_wr,
  input  logic [REG_ADDR-1:0] i_wb_rd,
  input  logic [XLEN-1:0]     i_wb_data,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [XLEN-1:0]     o_pc,
  output logic [CTRL_W-1:0]   o_ctrl,
  output logic                o_mem_rd,
  output logic [REG_ADDR-1:0] o_rd,
  output logic [XLEN-1:0]     o_rs1_data,
  output logic [XLEN-1:0]     o_rs2_data,
  output logic [XLEN-1:0]     o_imm,
  output logic [STAT_W-1:0]   o_bubble_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [CTRL_W-1:0]   ctrl;
    logic                mem_rd;
    logic [REG_ADDR-1:0] rd;
    logic [REG_ADDR-1:0] rs1_addr;
    logic [REG_ADDR-1:0] rs2_addr;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic [XLEN-1:0]     imm;
  } entry_t;

  entry_t              main_q, main_d;
  entry_t              skid_q, skid_d;
  logic                main_v_q, main_v_d;
  logic                skid_v_q, skid_v_d;
  logic [STAT_W-1:0]   cnt_q, cnt_d;

  entry_t              in_e, in_b;
  entry_t              main_h, skid_h;
  logic                wb_ok;
  logic                hit1, hit2;
  logic                haz, up, dn;

  // Register x0 is never a bypass source.
  function automatic entry_t byp(
    input entry_t              e,
    input logic                ok,
    input logic [REG_ADDR-1:0] wrd,
    input logic [XLEN-1:0]     wd
  );
    entry_t r;
    r = e;
    if (ok && e.rs1_addr == wrd)
      r.rs1_data = wd;
    if (ok && e.rs2_addr == wrd)
      r.rs2_data = wd;
    return r;
  endfunction

  assign wb_ok = i_wb_wr & (i_wb_rd != '0);

  always_comb begin
    in_e          = '0;
    in_e.pc       = i_pc;
    in_e.ctrl     = i_ctrl;
    in_e.mem_rd   = i_mem_rd;
    in_e.rd       = i_rd;
    in_e.rs1_addr = i_rs1_addr;
    in_e.rs2_addr = i_rs2_addr;
    in_e.rs1_data = i_rs1_data;
    in_e.rs2_data = i_rs2_data;
    in_e.imm      = i_imm;
  end

  assign in_b   = byp(in_e, wb_ok, i_wb_rd, i_wb_data);
  assign main_h = byp(main_q, wb_ok, i_wb_rd, i_wb_data);
  assign skid_h = byp(skid_q, wb_ok, i_wb_rd, i_wb_data);

  assign hit1 = i_rs1_used & (i_rs1_addr == main_q.rd);
  assign hit2 = i_rs2_used & (i_rs2_addr == main_q.rd);
  assign haz  = i_valid & main_v_q & main_q.mem_rd
              & (main_q.rd != '0) & (hit1 | hit2);

  assign o_ready = clk_en & rst_n & ~i_flush
                 & ~skid_v_q & ~haz;
  assign up = i_valid & o_ready;
  assign dn = main_v_q & i_ready & clk_en;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    cnt_d    = cnt_q;
    if (clk_en) begin
      main_d = main_h;
      skid_d = skid_h;
      if (haz && !skid_v_q && !i_flush
          && cnt_q != {STAT_W{1'b1}})
        cnt_d = cnt_q + 1'b1;
      if (i_flush) begin
        main_v_d = 1'b0;
        skid_v_d = 1'b0;
      end else if (!main_v_q || dn) begin
        // Skid is older than anything upstream.
        if (skid_v_q) begin
          main_d   = skid_h;
          main_v_d = 1'b1;
          skid_v_d = 1'b0;
        end else begin
          main_v_d = up;
          if (up)
            main_d = in_b;
        end
      end else if (up) begin
        skid_d   = in_b;
        skid_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_valid      = main_v_q;
  assign o_pc         = main_q.pc;
  assign o_ctrl       = main_q.ctrl;
  assign o_mem_rd     = main_q.mem_rd;
  assign o_rd         = main_q.rd;
  assign o_rs1_data   = main_q.rs1_data;
  assign o_rs2_data   = main_q.rs2_data;
  assign o_imm        = main_q.imm;
  assign o_bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Scoreboard bench for id_ex_skid_stage: directed scenarios
// followed by randomized traffic against a queue model.
module tb_id_ex_skid_stage;

  localparam int SW  = 2;
  localparam int SAT = (1 << SW) - 1;

  logic        clk;
  logic        rst_n, clk_en, i_flush;
  logic        i_valid, o_ready;
  logic [31:0] i_pc;
  logic [15:0] i_ctrl;
  logic        i_mem_rd;
  logic [4:0]  i_rd, i_rs1_addr, i_rs2_addr;
  logic        i_rs1_used, i_rs2_used;
  logic [31:0] i_rs1_data, i_rs2_data, i_imm;
  logic        i_wb_wr;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic        i_ready, o_valid;
  logic [31:0] o_pc;
  logic [15:0] o_ctrl;
  logic        o_mem_rd;
  logic [4:0]  o_rd;
  logic [31:0] o_rs1_data, o_rs2_data, o_imm;
  logic [SW-1:0] o_bubble_cnt;

  id_ex_skid_stage #(.STAT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_pc(i_pc), .i_ctrl(i_ctrl),
    .i_mem_rd(i_mem_rd), .i_rd(i_rd),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_imm(i_imm), .i_wb_wr(i_wb_wr), .i_wb_rd(i_wb_rd),
    .i_wb_data(i_wb_data), .i_ready(i_ready),
    .o_valid(o_valid), .o_pc(o_pc), .o_ctrl(o_ctrl),
    .o_mem_rd(o_mem_rd), .o_rd(o_rd),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_imm(o_imm), .o_bubble_cnt(o_bubble_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [15:0] ctrl;
    logic        mem_rd;
    logic [4:0]  rd, a1, a2;
    logic [31:0] d1, d2, imm;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   armed  = 0;
  int   exp_cnt = 0;
  bit   exp_ready, m_haz;
  int   m_size;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic ent_t wbfix(input ent_t e);
    ent_t r = e;
    if (i_wb_wr && i_wb_rd != 0) begin
      if (e.a1 == i_wb_rd) r.d1 = i_wb_data;
      if (e.a2 == i_wb_rd) r.d2 = i_wb_data;
    end
    return r;
  endfunction

  function automatic ent_t cur_in();
    ent_t e;
    e.pc = i_pc; e.ctrl = i_ctrl;
    e.mem_rd = i_mem_rd; e.rd = i_rd;
    e.a1 = i_rs1_addr; e.a2 = i_rs2_addr;
    e.d1 = i_rs1_data; e.d2 = i_rs2_data;
    e.imm = i_imm;
    return e;
  endfunction

  task automatic put(input bit v, input logic [31:0] pc,
                     input bit ld, input logic [4:0] rd,
                     input logic [4:0] a1, input bit u1,
                     input logic [4:0] a2, input bit u2);
    i_valid = v; i_pc = pc; i_mem_rd = ld; i_rd = rd;
    i_rs1_addr = a1; i_rs1_used = u1;
    i_rs2_addr = a2; i_rs2_used = u2;
    i_ctrl = 16'($urandom);
    i_imm = $urandom;
    i_rs1_data = $urandom;
    i_rs2_data = $urandom;
  endtask

  // One cycle: predict/check the handshake, then advance the model.
  task automatic tick();
    @(negedge clk);
    #1;
    m_size = sb.size();
    m_haz = i_valid && m_size > 0 && sb[0].mem_rd
         && sb[0].rd != 0
         && ((i_rs1_used && i_rs1_addr == sb[0].rd)
          || (i_rs2_used && i_rs2_addr == sb[0].rd));
    exp_ready = clk_en && rst_n && !i_flush
             && m_size < 2 && !m_haz;
    chk("o_ready", o_ready, exp_ready);
    if (armed) chk("bubble_cnt", o_bubble_cnt, exp_cnt);
    @(posedge clk);
    if (!rst_n) begin
      sb.delete();
      exp_cnt = 0;
      armed = 1;
    end else if (clk_en) begin
      if (m_haz && m_size < 2 && !i_flush && exp_cnt < SAT)
        exp_cnt++;
      if (i_flush) sb.delete();
      else begin
        foreach (sb[k]) sb[k] = wbfix(sb[k]);
        if (i_valid && exp_ready)
          sb.push_back(wbfix(cur_in()));
      end
    end
    #1;
  endtask

  // Monitor: head of the scoreboard must sit on the outputs.
  always @(negedge clk) begin
    #2;
    if (armed && rst_n) begin
      chk("o_valid", o_valid, sb.size() != 0);
      if (o_valid && sb.size() > 0) begin
        chk("pc", o_pc, sb[0].pc);
        chk("ctrl", o_ctrl, sb[0].ctrl);
        chk("mem_rd_rd", {o_mem_rd, o_rd},
            {sb[0].mem_rd, sb[0].rd});
        chk("rs1_data", o_rs1_data, sb[0].d1);
        chk("rs2_data", o_rs2_data, sb[0].d2);
        chk("imm", o_imm, sb[0].imm);
        if (i_ready && clk_en) void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst_n = 0; clk_en = 1; i_flush = 0; i_ready = 0;
    i_wb_wr = 0; i_wb_rd = 0; i_wb_data = 0;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1;
    chk("rst_pc", o_pc, 0);
    chk("rst_data", {o_rs1_data, o_rs2_data}, 0);
    chk("rst_misc",
        {o_valid, o_ctrl, o_mem_rd, o_rd, o_imm}, 0);
    chk("rst_cnt", o_bubble_cnt, 0);

    i_ready = 1;
    for (int n = 0; n < 4; n++) begin
      put(1, 32'(n * 4), 0, 1, 2, 1, 3, 1);
      tick();
    end
    put(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    i_ready = 0;
    put(1, 32'h20, 0, 1, 2, 1, 3, 1); tick();
    put(1, 32'h10, 0, 1, 2, 1, 3, 1); tick();
    put(1, 32'h14, 0, 1, 2, 1, 3, 1);
    #1 chk("bp_ready", o_ready, 0);
    tick();
    i_ready = 1;
    tick(); tick();
    put(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    i_ready = 0;
    put(1, 32'h40, 1, 5, 1, 1, 2, 1); tick();
    put(1, 32'h44, 0, 6, 5, 1, 2, 0);
    i_ready = 1;
    tick(); tick();
    put(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("lu_bubble", o_bubble_cnt, 1);
    i_ready = 0;
    put(1, 32'h50, 1, 0, 1, 1, 2, 1); tick();
    put(1, 32'h54, 0, 6, 0, 1, 0, 1);
    i_ready = 1;
    tick();
    put(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("x0_no_bubble", o_bubble_cnt, 1);

    i_ready = 0;
    put(1, 32'h60, 0, 1, 2, 1, 7, 1); tick();
    put(0, 0, 0, 0, 0, 0, 0, 0);
    i_wb_wr = 1; i_wb_rd = 7; i_wb_data = 32'hDEADBEEF;
    tick();
    i_wb_wr = 0;
    chk("byp_held", o_rs2_data, 32'hDEADBEEF);
    i_ready = 1;
    tick();
    put(1, 32'h64, 0, 1, 2, 1, 7, 1);
    i_rs2_data = 32'h1;
    i_wb_wr = 1;
    tick();
    i_wb_wr = 0;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    chk("byp_capture", o_rs2_data, 32'hDEADBEEF);
    put(1, 32'h68, 0, 1, 2, 1, 0, 1);
    i_wb_wr = 1; i_wb_rd = 0;
    tick();
    i_wb_wr = 0;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    i_ready = 0;
    put(1, 32'h70, 0, 1, 2, 1, 3, 1); tick();
    put(1, 32'h74, 0, 1, 2, 1, 3, 1); tick();
    put(1, 32'h78, 0, 1, 2, 1, 3, 1);
    i_flush = 1;
    tick();
    i_flush = 0;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_valid", o_valid, 0);
    tick();
    put(1, 32'h80, 0, 1, 2, 1, 3, 1); tick();
    put(1, 32'h84, 0, 1, 2, 1, 3, 1); tick();
    put(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 0; clk_en = 0;
    tick();
    rst_n = 1; clk_en = 1;
    chk("rst_clr_valid", o_valid, 0);
    chk("rst_clr_cnt", o_bubble_cnt, 0);
    chk("rst_clr_pc", o_pc, 0);

    put(1, 32'h90, 1, 5, 1, 1, 2, 1); tick();
    put(1, 32'h94, 0, 6, 5, 1, 2, 0);
    repeat (5) tick();
    chk("sat", o_bubble_cnt, 3);
    clk_en = 0;
    tick(); tick();
    chk("sat_hold", o_bubble_cnt, 3);
    clk_en = 1; i_ready = 1;
    tick(); tick();
    put(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    for (int n = 0; n < 3000; n++) begin
      put(($urandom % 10) < 7, $urandom,
          ($urandom % 3) == 0, 5'($urandom % 8),
          5'($urandom % 8), 1'($urandom),
          5'($urandom % 8), 1'($urandom));
      clk_en  = ($urandom % 10) != 0;
      i_flush = ($urandom % 32) == 0;
      i_ready = ($urandom % 3) != 0;
      i_wb_wr = 1'($urandom);
      i_wb_rd = 5'($urandom % 8);
      i_wb_data = $urandom;
      tick();
    end
    put(0, 0, 0, 0, 0, 0, 0, 0);
    clk_en = 1; i_flush = 0; i_ready = 1; i_wb_wr = 0;
    repeat (4) tick();
    chk("drain_valid", o_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
